// File: rtl/alu_result_checker_pkg.sv
// Shared definitions for the ALU result checker: opcodes, FSM states,
// width helpers and the reference model used to build expected results.
package alu_pkg;

    localparam int MAX_OPW = 32;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE
    } state_e;

    function automatic int opnd_w(input int nb);
        return nb + 1;
    endfunction

    function automatic int res_w(input int nb);
        return nb + 2;
    endfunction

    // Returns {y, co}, computed at the widest supported size and masked down to
    // nb+2 result bits, so the low res_w(nb)+1 bits are the packed entry.
    function automatic logic [MAX_OPW+1:0] calc_exp(input logic [2:0] op,
                                                    input logic [MAX_OPW-1:0] a,
                                                    input logic [MAX_OPW-1:0] b,
                                                    input int nb);
        logic [MAX_OPW:0] ea, eb, ym, om, r;
        logic co;
        ea = {1'b0, a};
        eb = {1'b0, b};
        ym = {(MAX_OPW+1){1'b1}} >> (MAX_OPW - 1 - nb);
        om = ym >> 1;
        co = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                r  = (ea + eb) & ym;
                co = |(r & ~om);
            end
            OP_SUB: begin
                r  = (ea - eb) & ym;
                co = (a < b);
            end
            OP_AND:  r = ea & eb;
            OP_OR:   r = ea | eb;
            OP_XOR:  r = ea ^ eb;
            OP_NOT:  r = ~ea & om;
            OP_SHL:  r = (ea << 1) & om;
            OP_SHR:  r = ea >> 1;
            default: r = '0;
        endcase
        return {r, co};
    endfunction

endpackage

// File: rtl/alu_result_checker_if.sv
// Issue/result stream observed by the checker.
interface alu_result_checker_if #(
    parameter int nbits = 7
);
    import alu_pkg::*;

    logic                       iss_valid;
    logic [opnd_w(nbits)-1:0]   iss_a;
    logic [opnd_w(nbits)-1:0]   iss_b;
    logic [2:0]                 iss_op;
    logic                       res_valid;
    logic [res_w(nbits)-1:0]    res_y;
    logic                       res_co;
    logic                       eos;

    modport master (output iss_valid, iss_a, iss_b, iss_op, res_valid, res_y, res_co, eos);
    modport slave  (input  iss_valid, iss_a, iss_b, iss_op, res_valid, res_y, res_co, eos);

endinterface

// File: rtl/alu_result_checker_op_fifo.sv
// In-order queue of expected results. A push and pop on an empty queue pass
// the pushed entry straight to dout without being stored.
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic                     bypass,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign bypass  = push && pop && empty;
    // When full, a simultaneous pop frees the slot being written this edge.
    assign do_push = push && !bypass && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = empty ? din : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_checker.sv
// Scoreboard that predicts ALU results at issue time and checks them in order
// as the ALU returns them, tracking pass/error counts and queue faults.
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int nbits = 7,
    parameter int depth = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_checker_if.slave bus,
    output logic                mismatch,
    output logic [15:0]         pass_cnt,
    output logic [15:0]         err_cnt,
    output logic                ovf_err,
    output logic                unf_err,
    output logic                busy,
    output logic                done
);
    localparam int EW = res_w(nbits) + 1;
    localparam int CW = $clog2(depth) + 1;

    state_e          state_q, state_d;
    logic            accept, push, full, empty, bypass;
    logic            unf_now, ovf_now, bad;
    logic [EW-1:0]   exp_in, exp_head;
    logic [CW-1:0]   count;

    assign accept = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign push   = bus.iss_valid && accept;
    assign exp_in = EW'(calc_exp(bus.iss_op, MAX_OPW'(bus.iss_a), MAX_OPW'(bus.iss_b), nbits));

    op_fifo #(.DEPTH(depth), .WIDTH(EW)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (bus.res_valid),
        .din    (exp_in),
        .dout   (exp_head),
        .full   (full),
        .empty  (empty),
        .bypass (bypass),
        .count  (count)
    );

    assign unf_now = bus.res_valid && empty && !bypass;
    assign ovf_now = (push && full && !bus.res_valid) || (bus.iss_valid && !accept);
    assign bad     = unf_now || (exp_head != {bus.res_y, bus.res_co});

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
            pass_cnt <= '0;
            err_cnt  <= '0;
            ovf_err  <= 1'b0;
            unf_err  <= 1'b0;
        end else begin
            mismatch <= bus.res_valid && bad;
            if (bus.res_valid) begin
                if (bad) begin
                    if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                end else if (pass_cnt != 16'hFFFF) begin
                    pass_cnt <= pass_cnt + 16'd1;
                end
            end
            if (ovf_now) ovf_err <= 1'b1;
            if (unf_now) unf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.eos)            state_d = ST_DONE;
                else if (bus.iss_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (bus.eos) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (count == '0 && !bus.res_valid) state_d = ST_DONE;
            end
            ST_DONE: done = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Randomized and directed bench for alu_result_checker against a queue-based
// reference model of the issue/result stream.
module tb_alu_result_checker;
    localparam int NB    = 7;
    localparam int DEPTH = 4;
    localparam int RMOD  = 1 << (NB + 2);
    localparam int OMOD  = 1 << (NB + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mismatch, ovf_err, unf_err, busy, done;
    logic [15:0] pass_cnt, err_cnt;

    alu_result_checker_if #(.nbits(NB)) bus ();

    alu_result_checker #(.nbits(NB), .depth(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mismatch (mismatch),
        .pass_cnt (pass_cnt),
        .err_cnt  (err_cnt),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected entries as y*2+co integers; phase 0..3 = idle/run/drain/done.
    int q[$];
    int m_pass, m_err, m_phase;
    bit m_ovf, m_unf, m_mis;

    function automatic int ref_exp(input int op, input int a, input int b);
        int y;
        int co;
        co = 0;
        case (op)
            0: begin y = a + b; co = (y / OMOD) % 2; y = y % RMOD; end
            1: begin y = (a - b + RMOD) % RMOD; co = (a < b) ? 1 : 0; end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: y = OMOD - 1 - a;
            6: y = (a * 2) % OMOD;
            default: y = a / 2;
        endcase
        return y * 2 + co;
    endfunction

    function automatic void model_step(input bit iv, input int a, input int b, input int op,
                                       input bit rv, input int y, input bit co, input bit e);
        int  sz, ex, want;
        bit  acc;
        if (rst) begin
            q.delete();
            m_pass = 0; m_err = 0; m_phase = 0;
            m_ovf = 0; m_unf = 0; m_mis = 0;
            return;
        end
        sz  = q.size();
        acc = (m_phase <= 1);
        ex  = ref_exp(op, a, b);
        m_mis = 0;
        if (rv) begin
            if (sz == 0 && !(iv && acc)) begin
                m_unf = 1; m_mis = 1;
                if (m_err < 65535) m_err++;
            end else begin
                if (sz == 0) want = ex;
                else begin
                    want = q.pop_front();
                    if (iv && acc) q.push_back(ex);
                end
                if (want == y * 2 + co) begin
                    if (m_pass < 65535) m_pass++;
                end else begin
                    m_mis = 1;
                    if (m_err < 65535) m_err++;
                end
            end
        end else if (iv && acc) begin
            if (sz == DEPTH) m_ovf = 1;
            else q.push_back(ex);
        end
        if (iv && !acc) m_ovf = 1;
        case (m_phase)
            0: if (e) m_phase = 3; else if (iv) m_phase = 1;
            1: if (e) m_phase = 2;
            2: if (sz == 0 && !rv) m_phase = 3;
            default: ;
        endcase
    endfunction

    task automatic cyc(input bit iv, input int a, input int b, input int op,
                       input bit rv, input int y, input bit co, input bit e);
        bus.iss_valid = iv;
        bus.iss_a     = (NB+1)'(a);
        bus.iss_b     = (NB+1)'(b);
        bus.iss_op    = 3'(op);
        bus.res_valid = rv;
        bus.res_y     = (NB+2)'(y);
        bus.res_co    = co;
        bus.eos       = e;
        @(posedge clk);
        model_step(iv, a, b, op, rv, y, co, e);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({mismatch, pass_cnt, err_cnt, ovf_err, unf_err, busy, done} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_state got m=%b p=%0d e=%0d o=%b u=%b b=%b d=%b want all 0",
                     mismatch, pass_cnt, err_cnt, ovf_err, unf_err, busy, done);
        end
    endtask

    task automatic test_add();
        do_reset();
        cyc(1, 200, 100, 0, 0, 0, 0, 0);
        idle();
        cyc(0, 0, 0, 0, 1, 'h12C, 1, 0);
        n_tests++;
        if (pass_cnt !== 16'd1 || mismatch !== 1'b0 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL add_pass got p=%0d m=%b e=%0d want p=1 m=0 e=0", pass_cnt, mismatch, err_cnt);
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL add_busy got %b want 1", busy);
        end
    endtask

    task automatic test_sub();
        do_reset();
        cyc(1, 5, 10, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 'h1FB, 0, 0);
        n_tests++;
        if (mismatch !== 1'b1 || err_cnt !== 16'd1 || pass_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL sub_mismatch got m=%b e=%0d p=%0d want m=1 e=1 p=0", mismatch, err_cnt, pass_cnt);
        end
        idle();
        n_tests++;
        if (mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_pulse_width got %b want 0", mismatch);
        end
    endtask

    task automatic test_overflow();
        int head;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), 0, 0, 0, 0);
            if (i == 3) begin
                n_tests++;
                if (ovf_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_early got %b want 0", ovf_err);
                end
            end
        end
        n_tests++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set got %b want 1", ovf_err);
        end
        for (int i = 0; i < 4; i++) begin
            head = q[0];
            cyc(0, 0, 0, 0, 1, head >> 1, head[0], 0);
        end
        n_tests++;
        if (pass_cnt !== 16'd4 || unf_err !== 1'b0 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL ovf_drain got p=%0d u=%b e=%0d want p=4 u=0 e=0", pass_cnt, unf_err, err_cnt);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        n_tests++;
        if (unf_err !== 1'b1 || err_cnt !== 16'd1 || mismatch !== 1'b1) begin
            n_fail++;
            $display("FAIL unf_empty got u=%b e=%0d m=%b want u=1 e=1 m=1", unf_err, err_cnt, mismatch);
        end
        do_reset();
        cyc(1, 'hF0, 'h0F, 4, 1, 'h0FF, 0, 0);
        n_tests++;
        if (pass_cnt !== 16'd1 || unf_err !== 1'b0 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL unf_bypass got p=%0d u=%b e=%0d want p=1 u=0 e=0", pass_cnt, unf_err, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int head;
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            head = q[0];
            cyc(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7),
                1, head >> 1, head[0], 0);
        end
        n_tests++;
        if (ovf_err !== 1'b0 || pass_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL b2b_full_pushpop got o=%b p=%0d want o=0 p=4", ovf_err, pass_cnt);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain got b=%b d=%b want b=1 d=0", busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            head = q[0];
            cyc(0, 0, 0, 0, 1, head >> 1, head[0], 0);
        end
        n_tests++;
        if (pass_cnt !== 16'd8 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_final got p=%0d d=%b want p=8 d=0", pass_cnt, done);
        end
        idle();
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done got d=%b b=%b want d=1 b=0", done, busy);
        end
        cyc(1, 1, 2, 0, 0, 0, 0, 0);
        n_tests++;
        if (ovf_err !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_in_done got o=%b d=%b want o=1 d=1", ovf_err, done);
        end
    endtask

    task automatic test_reset_mid();
        int head;
        do_reset();
        for (int i = 0; i < 3; i++)
            cyc(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), 0, 0, 0, 0);
        head = q[0];
        rst = 1'b1;
        cyc(0, 0, 0, 0, 1, head >> 1, head[0] ^ 1'b1, 0);
        rst = 1'b0;
        n_tests++;
        if ({mismatch, pass_cnt, err_cnt, ovf_err, unf_err, busy, done} !== 37'd0) begin
            n_fail++;
            $display("FAIL mid_reset got m=%b p=%0d e=%0d o=%b u=%b b=%b d=%b want all 0",
                     mismatch, pass_cnt, err_cnt, ovf_err, unf_err, busy, done);
        end
        cyc(0, 0, 0, 0, 1, head >> 1, head[0], 0);
        n_tests++;
        if (unf_err !== 1'b1 || err_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_reset_unf got u=%b e=%0d want u=1 e=1", unf_err, err_cnt);
        end
    endtask

    task automatic test_random();
        int a, b, op, want;
        bit iv, rv;
        logic [36:0] obs, expv;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            iv   = ($urandom_range(0, 2) != 0);
            rv   = ($urandom_range(0, 1) != 0);
            a    = $urandom_range(0, 255);
            b    = $urandom_range(0, 255);
            op   = $urandom_range(0, 7);
            want = (q.size() > 0) ? q[0] : ref_exp(op, a, b);
            if ($urandom_range(0, 4) == 0) want = want ^ (1 << $urandom_range(0, NB + 2));
            cyc(iv, a, b, op, rv, want >> 1, want[0], 0);
            obs  = {mismatch, pass_cnt, err_cnt, ovf_err, unf_err, busy, done};
            expv = {m_mis, 16'(m_pass), 16'(m_err), m_ovf, m_unf,
                    (m_phase == 1 || m_phase == 2), (m_phase == 3)};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random_cycle_%0d got %h want %h", i, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

Interface
REQ-001 Parameter nbits, default 7: operand MSB index; operands are nbits+1 bits, results nbits+2 bits.
REQ-002 Parameter depth, default 4: pending-operation queue depth, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 iss_valid  input  1  an operation was issued to the ALU this cycle.
REQ-006 iss_a, iss_b  input  nbits+1 each  issued operands.
REQ-007 iss_op  input  3  issued opcode.
REQ-008 res_valid  input  1  the ALU presents a result this cycle.
REQ-009 res_y  input  nbits+2  ALU result Y.
REQ-010 res_co  input  1  ALU carry/borrow out.
REQ-011 eos  input  1  end of stream; no further issues follow.
REQ-012 mismatch  output  1  one-cycle pulse on a failed compare.
REQ-013 pass_cnt, err_cnt  output  16 each  saturating compare counters.
REQ-014 ovf_err, unf_err  output  1 each  sticky queue overflow/underflow flags.
REQ-015 busy, done  output  1 each  checker status.

Function
REQ-016 Expected model: 000 ADD Y=A+B, co=Y[nbits+1]; 001 SUB Y=A-B mod 2^(nbits+2), co=(A<B); 010 AND; 011 OR; 100 XOR; 101 NOT A; 110 A<<1; 111 A>>1. Logic/shift results are zero-extended to nbits+2 bits with co=0.
REQ-017 On each iss_valid cycle, the expected {Y,co} is computed and pushed into the in-order queue.
REQ-018 On each res_valid cycle, the head entry is popped and compared with {res_y,res_co}.
REQ-019 Compare outcome is registered: mismatch and counter updates occur exactly one cycle after the res_valid edge.
REQ-020 A match increments pass_cnt; a mismatch increments err_cnt and pulses mismatch; both counters saturate at 16'hFFFF.
REQ-021 Push and pop in the same cycle are legal at any occupancy, including full; occupancy is unchanged.
REQ-022 A push while full with no pop sets ovf_err; the new entry is dropped and queue contents are unchanged.
REQ-023 A pop while empty with no push sets unf_err, increments err_cnt, and pulses mismatch.
REQ-024 A pop while empty with a simultaneous push compares against the entry being pushed (bypass).
REQ-025 Queue pointers wrap modulo depth; occupancy ranges 0..depth.
REQ-026 FSM states: IDLE, RUN, DRAIN, DONE; IDLE->RUN on iss_valid; RUN->DRAIN on eos; DRAIN->DONE when the queue is empty and no compare is pending; DONE holds until rst.
REQ-027 busy=1 in RUN and DRAIN; done=1 only in DONE. eos in IDLE goes directly to DONE.
REQ-028 iss_valid in DRAIN or DONE sets ovf_err, and the operation is not queued.

Reset
REQ-029 rst clears the queue, pointers, occupancy, counters, and sticky flags, and sets the FSM to IDLE, mismatch=0, busy=0, done=0.
REQ-030 rst has priority over all inputs in the same cycle; a compare pending at reset assertion is discarded.

Structure
REQ-031 Package alu_pkg holds the opcode constants, FSM state encoding, and width functions derived from nbits.
REQ-032 The queue is a sub-module op_fifo (depth, width parameters; push, pop, full, empty, count, bypass); expected-value computation is a function in alu_pkg.

Verification
REQ-033 ADD A=200, B=100, result Y=300 (9'h12C), co=1 two cycles later -> pass_cnt=1, mismatch=0.
REQ-034 SUB A=5, B=10, result Y=9'h1FB, co=0 -> mismatch pulse one cycle after res_valid, err_cnt=1.
REQ-035 Issue 5 operations with no results (depth=4) -> ovf_err=1 on the 5th issue; then 4 correct results -> pass_cnt=4, unf_err=0.
REQ-036 res_valid with an empty queue -> unf_err=1, err_cnt=1; a simultaneous issue of XOR 8'hF0, 8'h0F and result 9'h0FF -> pass with no underflow.
REQ-037 Eight back-to-back operations with the queue full and a push plus pop every cycle, then eos -> DRAIN, done=1 one cycle after the final compare, pass_cnt=8.
REQ-038 rst asserted mid-RUN with 3 entries queued -> the next cycle shows all counters and flags at 0 and state IDLE; a later result pop sets unf_err.
